// File: rtl/mha_head_sequencer.sv
// Multi-head attention sequencer: slices each token's embedding into head columns, drives one
// shared attention engine per enabled head, and reassembles the per-head results.
module mha_head_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int SEQ_LEN        = 64,
    parameter int EMBED_DIM      = 64,
    parameter int NUM_HEADS      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic                                     causal_en,
    input  logic [NUM_HEADS-1:0]                     head_en,
    input  logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0]  input_tokens_flat,
    output logic                                     eng_start,
    output logic                                     eng_causal,
    output logic [DATA_WIDTH*SEQ_LEN*(EMBED_DIM/NUM_HEADS)-1:0] eng_in_flat,
    input  logic                                     eng_done,
    input  logic [DATA_WIDTH*SEQ_LEN*(EMBED_DIM/NUM_HEADS)-1:0] eng_out_flat,
    output logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0]  output_tokens_flat,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     timeout_err,
    output logic [$clog2(NUM_HEADS):0]               head_idx,
    output logic [2:0]                               fsm_debug_state
);

    localparam int HEAD_DIM = EMBED_DIM / NUM_HEADS;
    localparam int IDX_W    = $clog2(NUM_HEADS) + 1;
    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SLICE_W  = HEAD_DIM * DATA_WIDTH;
    localparam int FULL_W   = DATA_WIDTH * SEQ_LEN * EMBED_DIM;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4,
        S_SKIP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t               state;
    logic [FULL_W-1:0]    tokens_lat;
    logic [NUM_HEADS-1:0] head_en_lat;
    logic [CNT_W-1:0]     wait_cnt;

    logic                 last_head;
    logic [IDX_W-1:0]     next_idx;
    logic                 next_en;

    assign last_head       = (head_idx == IDX_W'(NUM_HEADS - 1));
    assign next_idx        = head_idx + IDX_W'(1);
    assign fsm_debug_state = state;

    // Enable bit of the head that follows the current one, decoded without an out-of-range select
    always_comb begin
        next_en = 1'b0;
        for (int i = 0; i < NUM_HEADS; i++) begin
            if (next_idx == IDX_W'(i)) begin
                next_en = head_en_lat[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            tokens_lat         <= '0;
            head_en_lat        <= '0;
            wait_cnt           <= '0;
            eng_start          <= 1'b0;
            eng_causal         <= 1'b0;
            eng_in_flat        <= '0;
            output_tokens_flat <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            timeout_err        <= 1'b0;
            head_idx           <= '0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tokens_lat         <= input_tokens_flat;
                        head_en_lat        <= head_en;
                        eng_causal         <= causal_en;
                        output_tokens_flat <= '0;
                        done               <= 1'b0;
                        timeout_err        <= 1'b0;
                        head_idx           <= '0;
                        busy               <= 1'b1;
                        state              <= head_en[0] ? S_LOAD : S_SKIP;
                    end
                end
                S_LOAD: begin
                    for (int t = 0; t < SEQ_LEN; t++) begin
                        eng_in_flat[t*SLICE_W +: SLICE_W] <=
                            tokens_lat[(t*EMBED_DIM + int'(head_idx)*HEAD_DIM)*DATA_WIDTH +: SLICE_W];
                    end
                    eng_start <= 1'b1;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        state <= S_STORE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_STORE, S_SKIP: begin
                    if (state == S_STORE) begin
                        for (int t = 0; t < SEQ_LEN; t++) begin
                            output_tokens_flat[(t*EMBED_DIM + int'(head_idx)*HEAD_DIM)*DATA_WIDTH +: SLICE_W] <=
                                eng_out_flat[t*SLICE_W +: SLICE_W];
                        end
                    end
                    if (last_head) begin
                        state <= S_DONE;
                    end else begin
                        head_idx <= next_idx;
                        state    <= next_en ? S_LOAD : S_SKIP;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
